mac_sequencer: RTL and testbench

- Multiply-accumulate controller wrapped around the team's pipelined unsigned multiplier (WIDTH-bit operands, LEVEL output stages, no reset, no stall).
- Accepts signed fixed-point operand pairs on a valid/ready stream and drives their magnitudes into the multiplier.
- Re-signs and accumulates returning products, then emits one rescaled, saturated dot-product result per stream terminated by a "last" beat.

---
 rtl/mac_sequencer.sv | 140 ++++++++++++++
 tb/tb_mac_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mac_sequencer.sv
// mac_sequencer: signed fixed-point dot-product controller around an external
// pipelined unsigned multiplier. Operand magnitudes go to the multiplier, a
// sign/last tag travels alongside, and returning products are re-signed,
// accumulated and rescaled into one saturated result per stream.
module mac_sequencer #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned LEVEL = 6,
  parameter int unsigned FRAC  = 20,
  parameter int unsigned GUARD = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_pdt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_sat
);

  localparam int unsigned ACC_W = 2 * WIDTH + GUARD + 1;
  localparam int unsigned DEPTH = LEVEL + 2;

  // Output clipping limits expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]        O_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        O_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]        mul_a_q, mul_a_d;
  logic [WIDTH-1:0]        mul_b_q, mul_b_d;
  logic [DEPTH-1:0]        tag_v_q, tag_v_d;
  logic [DEPTH-1:0]        tag_n_q, tag_n_d;
  logic [DEPTH-1:0]        tag_l_q, tag_l_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic                    accept_c;
  logic [WIDTH-1:0]        mag_a_c, mag_b_c;
  logic signed [ACC_W-1:0] pdt_ext_c, term_c, sum_c, shifted_c;

  // Datapath helpers: handshake, operand magnitudes, re-signed term and sum.
  always_comb begin
    accept_c  = in_valid && !busy_q;
    mag_a_c   = in_a[WIDTH-1] ? (~in_a + WIDTH'(1)) : in_a;
    mag_b_c   = in_b[WIDTH-1] ? (~in_b + WIDTH'(1)) : in_b;
    pdt_ext_c = $signed(ACC_W'(mul_pdt));
    term_c    = tag_n_q[DEPTH-1] ? -pdt_ext_c : pdt_ext_c;
    sum_c     = acc_q + term_c;
    shifted_c = sum_c >>> FRAC;
  end

  // Next-state: operand capture, tag shift, accumulate/finish, flow control.
  always_comb begin
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    tag_v_d     = {tag_v_q[DEPTH-2:0], accept_c};
    tag_n_d     = {tag_n_q[DEPTH-2:0], in_a[WIDTH-1] ^ in_b[WIDTH-1]};
    tag_l_d     = {tag_l_q[DEPTH-2:0], in_last};
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    if (accept_c) begin
      mul_a_d = mag_a_c;
      mul_b_d = mag_b_c;
      if (in_last) busy_d = 1'b1;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end

    if (tag_v_q[DEPTH-1]) begin
      if (tag_l_q[DEPTH-1]) begin
        acc_d       = '0;
        out_valid_d = 1'b1;
        if (shifted_c > S_MAX) begin
          out_data_d = O_MAX;
          out_sat_d  = 1'b1;
        end else if (shifted_c < S_MIN) begin
          out_data_d = O_MIN;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = shifted_c[WIDTH-1:0];
          out_sat_d  = 1'b0;
        end
      end else begin
        acc_d = sum_c;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_v_q     <= '0;
      tag_n_q     <= '0;
      tag_l_q     <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_v_q     <= tag_v_d;
      tag_n_q     <= tag_n_d;
      tag_l_q     <= tag_l_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = !busy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with a behavioural pipelined multiplier.
module tb_mac_sequencer;

  localparam int unsigned WIDTH = 40;
  localparam int unsigned LEVEL = 6;
  localparam int unsigned FRAC  = 20;
  localparam int unsigned GUARD = 8;

  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1048576);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             sat;
  } exp_t;

  logic                 clk_in = 1'b0;
  logic                 rst_n_in = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_last = 1'b0;
  logic [WIDTH-1:0]     in_a = '0;
  logic [WIDTH-1:0]     in_b = '0;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic [2*WIDTH-1:0]   mul_pdt;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [WIDTH-1:0]     out_data;
  logic                 out_sat;

  int tests = 0;
  int fails = 0;
  exp_t sb_q[$];

  mac_sequencer #(.WIDTH(WIDTH), .LEVEL(LEVEL), .FRAC(FRAC), .GUARD(GUARD)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_pdt   (mul_pdt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk_in = ~clk_in;

  // Multiplier model: input register then LEVEL output stages, no reset.
  logic [WIDTH-1:0]   mr_a, mr_b;
  logic [2*WIDTH-1:0] mp [LEVEL];
  always @(posedge clk_in) begin
    mr_a  <= mul_a;
    mr_b  <= mul_b;
    mp[0] <= (2*WIDTH)'(mr_a) * (2*WIDTH)'(mr_b);
    for (int k = 1; k < LEVEL; k++) mp[k] <= mp[k-1];
  end
  assign mul_pdt = mp[LEVEL-1];

  task automatic chk(input string name, input logic [2*WIDTH-1:0] act, input logic [2*WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_n_in && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_sat", out_sat, e.sat);
        end
      end
    end
  end

  // Drive one beat and wait (bounded) for its accept edge; returns at edge+1.
  task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic last,
                      input logic chk_ready, input logic [WIDTH-1:0] ed, input logic es);
    int n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    if (chk_ready) chk("in_ready_streaming", in_ready, 1);
    while (!in_ready && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (n >= 200) chk("accept_timeout", 1, 0);
    if (last) sb_q.push_back('{data: ed, sat: es});
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (n >= 100) chk("out_valid_timeout", 1, 0);
  endtask

  initial begin
    int n;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_mul_a", mul_a, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Single beat with latency measurement: 3.0 * 2.0 = 6.0
    beat(WIDTH'(3145728), WIDTH'(2097152), 1'b1, 1'b0, WIDTH'(6291456), 1'b0);
    wait_valid(n);
    chk("latency", n, LEVEL + 2);
    @(posedge clk_in); #1;

    // Mixed signs: -1.5*2.0 + 0.5*0.5 = -2.75
    beat(-WIDTH'(1572864), WIDTH'(2097152), 1'b0, 1'b0, '0, 1'b0);
    beat(WIDTH'(524288), WIDTH'(524288), 1'b1, 1'b1, -WIDTH'(2883584), 1'b0);
    // Smallest negative product floors to -1 LSB
    beat(-WIDTH'(1), WIDTH'(1), 1'b1, 1'b0, -WIDTH'(1), 1'b0);

    // Saturation both directions
    beat(MAXV, MAXV, 1'b1, 1'b0, MAXV, 1'b1);
    beat(MINV, MAXV, 1'b1, 1'b0, MINV, 1'b1);

    // Throughput: 16 back-to-back beats of 1.0*1.0
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk_in); #1; n++; end
    for (int i = 0; i < 16; i++)
      beat(ONE, ONE, 1'b1 && (i == 15), 1'b1, WIDTH'(16777216), 1'b0);

    // Backpressure: hold 1.5*1.5 = 2.25 for 20 cycles
    wait_valid(n);
    @(posedge clk_in); #1;
    out_ready = 1'b0;
    beat(WIDTH'(1572864), WIDTH'(1572864), 1'b1, 1'b1, WIDTH'(2359296), 1'b0);
    wait_valid(n);
    for (int i = 0; i < 20; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, WIDTH'(2359296));
      chk("bp_out_sat", out_sat, 0);
      @(posedge clk_in); #1;
    end
    out_ready = 1'b1;
    @(posedge clk_in); #1;
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_out_valid", out_valid, 0);
    beat(WIDTH'(2097152), WIDTH'(2097152), 1'b1, 1'b1, WIDTH'(4194304), 1'b0);
    wait_valid(n);
    @(posedge clk_in); #1;

    // Reset mid-stream after 3 partial beats
    for (int i = 0; i < 3; i++) beat(ONE, ONE, 1'b0, 1'b1, '0, 1'b0);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_mul_a", mul_a, 0);
    chk("mid_rst_mul_b", mul_b, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_sat", out_sat, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    beat(ONE, ONE, 1'b1, 1'b1, ONE, 1'b0);

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin @(posedge clk_in); #1; n++; end
    chk("scoreboard_drained", sb_q.size(), 0);
    @(posedge clk_in); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
